// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver and transmitter.
//   uart_state_e  - frame FSM encoding (IDLE/START/DATA/STOP)
//   DATA_BITS     - payload bits per frame
//   OVS           - oversample ticks per bit
//   MID_SAMPLE    - tick count at the middle of the start bit
//   calc_tick_div - clock cycles per oversample tick, rounded to nearest
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_e;

   localparam int DATA_BITS  = 8;
   localparam int OVS        = 16;
   localparam int MID_SAMPLE = OVS/2 - 1;

   function automatic int calc_tick_div(input int clk_freq, input int baud);
      return (clk_freq + (baud*OVS)/2) / (baud*OVS);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side handshake of the receiver.
//   rd_ack     - consumer acknowledge pulse (clears data_valid / overrun)
//   data_out   - last received byte
//   data_valid - data_out holds an unacknowledged byte
//   frame_err  - 1-cycle pulse on a low stop bit
//   overrun    - sticky, a byte arrived while data_valid was still set
//   busy       - a frame is being received
// master: the receiver (produces bytes); slave: the consumer.
interface uart_rx_if;

   logic                               rd_ack;
   logic [uart_rx_pkg::DATA_BITS-1:0]  data_out;
   logic                               data_valid;
   logic                               frame_err;
   logic                               overrun;
   logic                               busy;

   modport master (input rd_ack, output data_out, data_valid, frame_err, overrun, busy);
   modport slave  (output rd_ack, input data_out, data_valid, frame_err, overrun, busy);

endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// baud_tick_gen: free-running divider producing a 1-cycle tick every TICK_DIV clocks.
//   clk_50M - system clock
//   rst     - async active-low reset
//   tick    - high for one cycle when the counter reaches TICK_DIV-1
module baud_tick_gen #(
   parameter int TICK_DIV = 27
) (
   input  logic clk_50M,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign tick = (r_cnt == CW'(TICK_DIV-1));

   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst)      r_cnt <= '0;
      else if (tick) r_cnt <= '0;
      else           r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and valid/ack output register.
//   clk_50M - system clock
//   rst     - async active-low reset
//   i_rx    - asynchronous serial line, idle high
//   bus     - byte handshake (uart_rx_if.master)
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD)
) (
   input  logic      clk_50M,
   input  logic      rst,
   input  logic      i_rx,
   uart_rx_if.master bus
);

   logic                 r_sync1, r_sync2;
   logic                 w_rx_s;
   logic                 w_tick;
   uart_state_e          r_state, w_state_nx;
   logic [3:0]           r_sc, w_sc_nx;
   logic [2:0]           r_bi, w_bi_nx;
   logic [DATA_BITS-1:0] r_shift, w_shift_nx;
   logic                 r_armed;
   logic                 w_load, w_ferr;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid, r_ferr, r_ovr;

   assign w_rx_s = r_sync2;

   baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_50M (clk_50M),
      .rst     (rst),
      .tick    (w_tick)
   );

   // synchronizer resets to the idle level so reset release is not a start edge
   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_sc    <= '0;
         r_bi    <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nx;
         r_sc    <= w_sc_nx;
         r_bi    <= w_bi_nx;
         r_shift <= w_shift_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_sc_nx    = r_sc;
      w_bi_nx    = r_bi;
      w_shift_nx = r_shift;
      w_load     = 1'b0;
      w_ferr     = 1'b0;
      if (w_tick) begin
         case (r_state)
            IDLE: begin
               if (r_armed && !w_rx_s) begin
                  w_state_nx = START;
                  w_sc_nx    = '0;
               end
            end
            START: begin
               if (r_sc == 4'(MID_SAMPLE)) begin
                  if (w_rx_s) begin
                     w_state_nx = IDLE;   // start bit gone by mid-bit: glitch
                  end else begin
                     w_state_nx = DATA;
                     w_sc_nx    = '0;
                     w_bi_nx    = '0;
                  end
               end else begin
                  w_sc_nx = r_sc + 1'b1;
               end
            end
            DATA: begin
               if (r_sc == 4'(OVS-1)) begin
                  w_shift_nx[r_bi] = w_rx_s;
                  w_sc_nx          = '0;
                  if (r_bi == 3'(DATA_BITS-1)) w_state_nx = STOP;
                  else                         w_bi_nx    = r_bi + 1'b1;
               end else begin
                  w_sc_nx = r_sc + 1'b1;
               end
            end
            STOP: begin
               if (r_sc == 4'(OVS-1)) begin
                  w_state_nx = IDLE;
                  w_sc_nx    = '0;
                  if (w_rx_s) w_load = 1'b1;
                  else        w_ferr = 1'b1;
               end else begin
                  w_sc_nx = r_sc + 1'b1;
               end
            end
            default: w_state_nx = IDLE;
         endcase
      end
   end

   // After a frame error the line must be seen high again before a new
   // start is accepted, so a held break reports only one frame error.
   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst)        r_armed <= 1'b0;
      else if (w_ferr) r_armed <= 1'b0;
      else if (w_rx_s) r_armed <= 1'b1;
   end

   // A load in the same cycle as rd_ack wins; overrun only sets when the
   // previous byte is still pending and not being acknowledged right now.
   always_ff @(posedge clk_50M or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            r_ovr   <= r_valid & ~bus.rd_ack;
         end else if (bus.rd_ack && r_valid) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
         end
      end
   end

   assign bus.data_out   = r_data;
   assign bus.data_valid = r_valid;
   assign bus.frame_err  = r_ferr;
   assign bus.overrun    = r_ovr;
   assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int BIT = 432;   // 16 ticks x 27 clocks

   logic clk_50M = 1'b0;
   logic rst     = 1'b0;
   logic rx      = 1'b1;

   uart_rx_if bus();

   uart_rx dut (
      .clk_50M (clk_50M),
      .rst     (rst),
      .i_rx    (rx),
      .bus     (bus)
   );

   always #10 clk_50M = ~clk_50M;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          fe_cnt = 0;
   int          dv_rise = 0;
   logic        dv_q = 1'b0;
   logic [7:0]  exp_q[$];

   always @(posedge clk_50M) cyc <= cyc + 1;

   always @(negedge clk_50M) begin
      if (bus.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
      if (bus.data_valid === 1'b1 && dv_q !== 1'b1) dv_rise <= cyc;
      dv_q <= bus.data_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_dv(input string tag, input int budget);
      int k = 0;
      while (bus.data_valid !== 1'b1 && k < budget) begin
         @(negedge clk_50M);
         k++;
      end
      if (bus.data_valid !== 1'b1) chk({tag, "_timeout"}, 32'(bus.data_valid), 32'd1);
   endtask

   // scoreboard pop: compare the DUT byte with the oldest expected one
   task automatic check_out(input string tag);
      logic [7:0] e;
      wait_dv(tag, 50);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_data"}, 32'(bus.data_out), 32'(e));
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk_50M);
   endtask

   // full 8N1 frame; the check/ack happen inside the stop bit so frames stay back-to-back
   task automatic send(input string tag, input logic [7:0] b, input logic stop,
                       input bit do_chk, input bit do_ack);
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
      rx = stop;
      repeat (BIT-2) @(negedge clk_50M);
      if (do_chk) check_out(tag);
      if (do_ack) bus.rd_ack = 1'b1;
      @(negedge clk_50M);
      bus.rd_ack = 1'b0;
      @(negedge clk_50M);
   endtask

   initial begin
      int t0, lat, fe0;
      logic [7:0] partial;
      bus.rd_ack = 1'b0;

      // reset state
      repeat (5) @(negedge clk_50M);
      chk("rst_data", 32'(bus.data_out), 32'h0);
      chk("rst_valid", 32'(bus.data_valid), 32'h0);
      chk("rst_ferr", 32'(bus.frame_err), 32'h0);
      chk("rst_ovr", 32'(bus.overrun), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      rst = 1'b1;
      repeat (2*BIT) @(negedge clk_50M);

      // single byte 'W' with latency check
      fe0 = fe_cnt;
      t0  = cyc;
      exp_q.push_back(8'h57);
      send("w57", 8'h57, 1'b1, 1'b1, 1'b1);
      lat = dv_rise - t0;
      chk("w57_latency_window", 32'(lat >= 4104 && lat <= 4140), 32'd1);
      chk("w57_busy_fall", 32'(bus.busy), 32'h0);
      chk("w57_acked", 32'(bus.data_valid), 32'h0);
      chk("w57_ferr", 32'(fe_cnt - fe0), 32'd0);
      repeat (BIT) @(negedge clk_50M);

      // back-to-back with acks
      exp_q.push_back(8'h2E);
      exp_q.push_back(8'h20);
      send("b2b_2e", 8'h2E, 1'b1, 1'b1, 1'b1);
      send("b2b_20", 8'h20, 1'b1, 1'b1, 1'b1);
      chk("b2b_ovr", 32'(bus.overrun), 32'h0);
      chk("b2b_valid", 32'(bus.data_valid), 32'h0);
      repeat (BIT) @(negedge clk_50M);

      // overrun: two bytes, no ack
      exp_q.push_back(8'h61);
      send("ovr_61", 8'h61, 1'b1, 1'b1, 1'b0);
      chk("ovr_first_no_ovr", 32'(bus.overrun), 32'h0);
      exp_q.push_back(8'h72);
      send("ovr_72", 8'h72, 1'b1, 1'b1, 1'b0);
      chk("ovr_set", 32'(bus.overrun), 32'h1);
      chk("ovr_valid", 32'(bus.data_valid), 32'h1);
      bus.rd_ack = 1'b1;
      @(negedge clk_50M);
      bus.rd_ack = 1'b0;
      chk("ovr_ack_valid", 32'(bus.data_valid), 32'h0);
      chk("ovr_ack_ovr", 32'(bus.overrun), 32'h0);
      repeat (2*BIT) @(negedge clk_50M);

      // 3 us glitch on idle line
      fe0 = fe_cnt;
      rx = 1'b0;
      repeat (100) @(negedge clk_50M);
      chk("glitch_busy_start", 32'(bus.busy), 32'h1);
      repeat (50) @(negedge clk_50M);
      rx = 1'b1;
      repeat (2*BIT) @(negedge clk_50M);
      chk("glitch_busy_end", 32'(bus.busy), 32'h0);
      chk("glitch_valid", 32'(bus.data_valid), 32'h0);
      chk("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

      // framing error then break
      fe0 = fe_cnt;
      send("ferr_6e", 8'h6E, 1'b0, 1'b0, 1'b0);
      chk("ferr_once", 32'(fe_cnt - fe0), 32'd1);
      chk("ferr_valid", 32'(bus.data_valid), 32'h0);
      repeat (5*BIT) @(negedge clk_50M);
      chk("break_no_second_ferr", 32'(fe_cnt - fe0), 32'd1);
      chk("break_busy", 32'(bus.busy), 32'h0);
      rx = 1'b1;
      repeat (2*BIT) @(negedge clk_50M);
      chk("break_valid", 32'(bus.data_valid), 32'h0);

      // reset mid-frame
      exp_q.push_back(8'h3C);
      send("pre_rst_3c", 8'h3C, 1'b1, 1'b1, 1'b0);
      repeat (BIT) @(negedge clk_50M);
      partial = 8'h55;
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive_bit(partial[i], BIT);
      rx = partial[4];
      repeat (BIT/2) @(negedge clk_50M);
      chk("mid_busy", 32'(bus.busy), 32'h1);
      rst = 1'b0;
      @(negedge clk_50M);
      chk("mrst_data", 32'(bus.data_out), 32'h0);
      chk("mrst_valid", 32'(bus.data_valid), 32'h0);
      chk("mrst_ovr", 32'(bus.overrun), 32'h0);
      chk("mrst_ferr", 32'(bus.frame_err), 32'h0);
      chk("mrst_busy", 32'(bus.busy), 32'h0);
      rx = 1'b1;
      repeat (10) @(negedge clk_50M);
      rst = 1'b1;
      repeat (2*BIT) @(negedge clk_50M);
      chk("post_rst_valid", 32'(bus.data_valid), 32'h0);
      exp_q.push_back(8'hA3);
      send("post_rst_a3", 8'hA3, 1'b1, 1'b1, 1'b1);
      chk("post_rst_ovr", 32'(bus.overrun), 32'h0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
